// File: rtl/trace_scheduler.sv
// Per-pixel ray-trace sequencer: walks the frame, tests every sphere, keeps the nearest hit, writes it out.
// Optional hit statistics (hit_count port and counter) are built when TRACE_STATS_EN is defined.
module trace_scheduler #(
  parameter int unsigned NUM_SPHERES = 4,
  parameter int unsigned H_RES       = 640,
  parameter int unsigned V_RES       = 480,
  parameter int unsigned LUT_LATENCY = 2,
  parameter logic [31:0] T_MAX       = 32'h7FFF0000,
  parameter logic [23:0] BG_COLOR    = 24'h000000,
  localparam int unsigned SW = (NUM_SPHERES > 1) ? $clog2(NUM_SPHERES) : 1
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic          start,
  output logic          busy,
  output logic          frame_done,
  output logic [9:0]    WriteX,
  output logic [9:0]    WriteY,
  output logic [SW-1:0] sph_idx,
  output logic [31:0]   tbest,
  input  logic          collide,
  input  logic [31:0]   tnew,
  input  logic [23:0]   sph_col,
  output logic          fb_we,
  output logic [23:0]   fb_color,
  input  logic          fb_ready
`ifdef TRACE_STATS_EN
  ,
  output logic [18:0]   hit_count
`endif
);

  localparam int unsigned LW = $clog2(LUT_LATENCY + 1);
  localparam logic [LW-1:0] LUT_LAST = LW'(LUT_LATENCY - 1);
  localparam logic [SW-1:0] S_LAST   = SW'(NUM_SPHERES - 1);
  localparam logic [9:0]    X_LAST   = 10'(H_RES - 1);
  localparam logic [9:0]    Y_LAST   = 10'(V_RES - 1);

  typedef enum logic [2:0] {IDLE, SETUP, TEST, WRITE, DONE} state_t;

  state_t        state;
  logic [LW-1:0] lut_cnt;
`ifdef TRACE_STATS_EN
  logic          pix_hit;
`endif

  // Sequencer and all registered outputs.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      lut_cnt    <= '0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      WriteX     <= '0;
      WriteY     <= '0;
      sph_idx    <= '0;
      tbest      <= T_MAX;
      fb_we      <= 1'b0;
      fb_color   <= BG_COLOR;
`ifdef TRACE_STATS_EN
      pix_hit    <= 1'b0;
      hit_count  <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            WriteX   <= '0;
            WriteY   <= '0;
            sph_idx  <= '0;
            tbest    <= T_MAX;
            fb_color <= BG_COLOR;
            lut_cnt  <= '0;
            busy     <= 1'b1;
            state    <= SETUP;
`ifdef TRACE_STATS_EN
            pix_hit   <= 1'b0;
            hit_count <= '0;
`endif
          end
        end
        // Hold the coordinates while the angle/ray LUTs settle.
        SETUP: begin
          if (lut_cnt == LUT_LAST) begin
            lut_cnt <= '0;
            state   <= TEST;
          end else begin
            lut_cnt <= lut_cnt + 1'b1;
          end
        end
        // Strict compare keeps the lower sphere index on equal distance.
        TEST: begin
          if (collide && (tnew < tbest)) begin
            tbest    <= tnew;
            fb_color <= sph_col;
`ifdef TRACE_STATS_EN
            pix_hit  <= 1'b1;
`endif
          end
          if (sph_idx == S_LAST) begin
            fb_we <= 1'b1;
            state <= WRITE;
          end else begin
            sph_idx <= sph_idx + 1'b1;
          end
        end
        WRITE: begin
          if (fb_ready) begin
            fb_we    <= 1'b0;
            tbest    <= T_MAX;
            fb_color <= BG_COLOR;
            sph_idx  <= '0;
`ifdef TRACE_STATS_EN
            pix_hit  <= 1'b0;
            if (pix_hit && (hit_count != '1)) hit_count <= hit_count + 19'd1;
`endif
            if ((WriteX == X_LAST) && (WriteY == Y_LAST)) begin
              state <= DONE;
            end else begin
              if (WriteX == X_LAST) begin
                WriteX <= '0;
                WriteY <= WriteY + 10'd1;
              end else begin
                WriteX <= WriteX + 10'd1;
              end
              state <= SETUP;
            end
          end
        end
        DONE: begin
          frame_done <= 1'b1;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trace_scheduler.sv
// Directed bench for trace_scheduler on a reduced 8x4 frame; stats scenario builds with TRACE_STATS_EN.
module tb_trace_scheduler;

  localparam int H = 8;
  localparam int V = 4;
  localparam int N = 4;
  localparam int L = 2;
  localparam logic [31:0] TMAX = 32'h7FFF0000;
  localparam logic [23:0] BG   = 24'h0A0B0C;
  localparam int FRAME = 7 * H * V + 1;

  logic        Clk, Reset_n, start;
  logic        busy, frame_done, fb_we, fb_ready, collide;
  logic [9:0]  WriteX, WriteY;
  logic [1:0]  sph_idx;
  logic [31:0] tbest, tnew;
  logic [23:0] sph_col, fb_color;
`ifdef TRACE_STATS_EN
  logic [18:0] hit_count;
`endif

  int total = 0;
  int bad   = 0;
  logic [1:0] mode;
  int lin;

  trace_scheduler #(
    .NUM_SPHERES(N), .H_RES(H), .V_RES(V), .LUT_LATENCY(L),
    .T_MAX(TMAX), .BG_COLOR(BG)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .start(start), .busy(busy), .frame_done(frame_done),
    .WriteX(WriteX), .WriteY(WriteY), .sph_idx(sph_idx), .tbest(tbest),
    .collide(collide), .tnew(tnew), .sph_col(sph_col),
    .fb_we(fb_we), .fb_color(fb_color), .fb_ready(fb_ready)
`ifdef TRACE_STATS_EN
    , .hit_count(hit_count)
`endif
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] tn_of(input logic [1:0] i);
    case (i)
      2'd0:    return 32'h00050000;
      2'd1:    return 32'h00030000;
      2'd2:    return 32'h00030000;
      default: return 32'h00040000;
    endcase
  endfunction

  function automatic logic [23:0] col_of(input logic [1:0] i);
    case (i)
      2'd0:    return 24'h0000FF;
      2'd1:    return 24'h00FF00;
      2'd2:    return 24'hFF0000;
      default: return 24'h808080;
    endcase
  endfunction

  assign lin = int'(WriteY) * H + int'(WriteX);

  // Sphere/collision model: mode 1 = nearest-hit table on pixel 0, 2 = hits on pixels 1,4,9, 3 = hit everywhere.
  always_comb begin
    collide = 1'b0;
    tnew    = '0;
    sph_col = '0;
    case (mode)
      2'd1: if (lin == 0) begin collide = 1'b1; tnew = tn_of(sph_idx); sph_col = col_of(sph_idx); end
      2'd2: if ((lin == 1 || lin == 4 || lin == 9) && sph_idx == 2'd0) begin
              collide = 1'b1; tnew = 32'h00010000; sph_col = 24'hABCDEF;
            end
      2'd3: begin collide = 1'b1; tnew = 32'h00001000; sph_col = 24'h5A5A5A; end
      default: ;
    endcase
  end

  task automatic do_reset();
    Reset_n = 1'b0; start = 1'b0; fb_ready = 1'b1; mode = 2'd0;
    @(negedge Clk); @(negedge Clk);
    Reset_n = 1'b1;
    @(negedge Clk);
  endtask

  task automatic test_reset();
    Reset_n = 1'b0; start = 1'b0; fb_ready = 1'b1; mode = 2'd0;
    @(negedge Clk); #1;
    total++;
    if ({busy, frame_done, fb_we, WriteX, WriteY, sph_idx, tbest, fb_color} !== {3'b000, 10'd0, 10'd0, 2'd0, TMAX, BG}) begin
      bad++; $display("FAIL reset_values got=%h exp=%h", {busy, frame_done, fb_we, WriteX, WriteY, sph_idx, tbest, fb_color},
                      {3'b000, 10'd0, 10'd0, 2'd0, TMAX, BG});
    end
`ifdef TRACE_STATS_EN
    total++;
    if (hit_count !== 19'd0) begin bad++; $display("FAIL reset_hit_count got=%0d exp=0", hit_count); end
`endif
    @(negedge Clk); Reset_n = 1'b1;
    repeat (3) @(negedge Clk);
    total++;
    if ({busy, fb_we, frame_done} !== 3'b000) begin bad++; $display("FAIL idle_no_start got=%b exp=000", {busy, fb_we, frame_done}); end
  endtask

  task automatic test_full_frame();
    int k, nw, done_k;
    logic [9:0] ex, ey;
    do_reset();
    start = 1'b1; @(posedge Clk); #1 start = 1'b0;
    k = 0; nw = 0; done_k = -1; ex = '0; ey = '0;
    while (done_k < 0 && k < 1000) begin
      @(negedge Clk);
      if (k == 0) begin
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL busy_after_start got=%b exp=1", busy); end
      end
      if (fb_we && fb_ready) begin
        total++;
        if ({WriteX, WriteY, fb_color} !== {ex, ey, BG}) begin
          bad++; $display("FAIL frame_write got=(%0d,%0d,%h) exp=(%0d,%0d,%h)", WriteX, WriteY, fb_color, ex, ey, BG);
        end
        nw++;
        if (ex == 10'(H - 1)) begin ex = '0; ey = ey + 10'd1; end else ex = ex + 10'd1;
      end
      if (frame_done) begin
        done_k = k;
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL busy_with_done got=%b exp=0", busy); end
      end
      @(posedge Clk); k++;
    end
    total++;
    if (done_k != FRAME) begin bad++; $display("FAIL frame_latency got=%0d exp=%0d", done_k, FRAME); end
    total++;
    if (nw != H * V) begin bad++; $display("FAIL frame_writes got=%0d exp=%0d", nw, H * V); end
  endtask

  task automatic test_nearest();
    int k;
    do_reset();
    mode = 2'd1;
    start = 1'b1; @(posedge Clk); #1 start = 1'b0;
    k = 0;
    @(negedge Clk);
    while (!fb_we && k < 50) begin @(posedge Clk); k++; @(negedge Clk); end
    total++;
    if (k != 6) begin bad++; $display("FAIL first_write_latency got=%0d exp=6", k); end
    total++;
    if ({fb_color, tbest, WriteX, WriteY} !== {24'h00FF00, 32'h00030000, 10'd0, 10'd0}) begin
      bad++; $display("FAIL nearest_hit got=(%h,%h,%0d,%0d) exp=(00ff00,00030000,0,0)", fb_color, tbest, WriteX, WriteY);
    end
    @(negedge Clk);
    total++;
    if ({fb_we, tbest, fb_color, sph_idx, WriteX} !== {1'b0, TMAX, BG, 2'd0, 10'd1}) begin
      bad++; $display("FAIL after_accept got=(%b,%h,%h,%0d,%0d) exp=(0,%h,%h,0,1)", fb_we, tbest, fb_color, sph_idx, WriteX, TMAX, BG);
    end
    k = 0;
    while (!fb_we && k < 50) begin @(negedge Clk); k++; end
    total++;
    if ({fb_color, WriteX} !== {BG, 10'd1}) begin
      bad++; $display("FAIL miss_pixel got=(%h,%0d) exp=(%h,1)", fb_color, WriteX, BG);
    end
  endtask

  task automatic test_backpressure();
    int k, nw, done_k, stalls;
    logic [9:0] ex, ey;
    do_reset();
    start = 1'b1; @(posedge Clk); #1 start = 1'b0;
    k = 0; nw = 0; done_k = -1; stalls = 0; ex = '0; ey = '0;
    while (done_k < 0 && k < 1000) begin
      @(negedge Clk);
      if (fb_we && WriteX == 10'(H - 1) && WriteY == 10'd0 && stalls < 5) begin
        fb_ready = 1'b0; stalls++;
        total++;
        if ({WriteX, WriteY, fb_color} !== {10'(H - 1), 10'd0, BG}) begin
          bad++; $display("FAIL stall_hold got=(%0d,%0d,%h) exp=(%0d,0,%h)", WriteX, WriteY, fb_color, H - 1, BG);
        end
      end else begin
        fb_ready = 1'b1;
      end
      if (fb_we && fb_ready) begin
        total++;
        if ({WriteX, WriteY, fb_color} !== {ex, ey, BG}) begin
          bad++; $display("FAIL bp_write got=(%0d,%0d,%h) exp=(%0d,%0d,%h)", WriteX, WriteY, fb_color, ex, ey, BG);
        end
        nw++;
        if (ex == 10'(H - 1)) begin ex = '0; ey = ey + 10'd1; end else ex = ex + 10'd1;
      end
      if (frame_done) done_k = k;
      @(posedge Clk); k++;
    end
    fb_ready = 1'b1;
    total++;
    if (stalls != 5) begin bad++; $display("FAIL stall_count got=%0d exp=5", stalls); end
    total++;
    if (done_k != FRAME + 5) begin bad++; $display("FAIL bp_latency got=%0d exp=%0d", done_k, FRAME + 5); end
    total++;
    if (nw != H * V) begin bad++; $display("FAIL bp_writes got=%0d exp=%0d", nw, H * V); end
  endtask

  task automatic test_start_mid_frame();
    int k, ndone, done_k;
    do_reset();
    start = 1'b1; @(posedge Clk); #1 start = 1'b0;
    ndone = 0; done_k = -1;
    for (k = 0; k < 260; k++) begin
      @(negedge Clk);
      if (k == 24) start = 1'b1;
      if (k == 25) begin
        start = 1'b0;
        total++;
        if ({busy, WriteX, WriteY} !== {1'b1, 10'd3, 10'd0}) begin
          bad++; $display("FAIL mid_start_coords got=(%b,%0d,%0d) exp=(1,3,0)", busy, WriteX, WriteY);
        end
      end
      if (frame_done) begin ndone++; done_k = k; end
      @(posedge Clk);
    end
    total++;
    if (ndone != 1 || done_k != FRAME) begin bad++; $display("FAIL mid_start_done got=%0d@%0d exp=1@%0d", ndone, done_k, FRAME); end
    @(negedge Clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL mid_start_idle got=%b exp=0", busy); end
  endtask

  task automatic test_reset_mid_test();
    int k;
    do_reset();
    mode = 2'd3;
    start = 1'b1; @(posedge Clk); #1 start = 1'b0;
    for (k = 0; k < 151; k++) @(posedge Clk);
    @(negedge Clk);
    total++;
    if ({WriteX, WriteY, sph_idx, tbest, fb_color} !== {10'd5, 10'd2, 2'd2, 32'h00001000, 24'h5A5A5A}) begin
      bad++; $display("FAIL pre_reset got=(%0d,%0d,%0d,%h,%h) exp=(5,2,2,00001000,5a5a5a)", WriteX, WriteY, sph_idx, tbest, fb_color);
    end
    #2 Reset_n = 1'b0;
    #1;
    total++;
    if ({busy, frame_done, fb_we, WriteX, WriteY, sph_idx, tbest, fb_color} !== {3'b000, 10'd0, 10'd0, 2'd0, TMAX, BG}) begin
      bad++; $display("FAIL async_reset got=%h exp=%h", {busy, frame_done, fb_we, WriteX, WriteY, sph_idx, tbest, fb_color},
                      {3'b000, 10'd0, 10'd0, 2'd0, TMAX, BG});
    end
`ifdef TRACE_STATS_EN
    total++;
    if (hit_count !== 19'd0) begin bad++; $display("FAIL async_reset_hits got=%0d exp=0", hit_count); end
`endif
    @(negedge Clk); Reset_n = 1'b1; mode = 2'd0;
    @(negedge Clk);
    start = 1'b1; @(posedge Clk); #1 start = 1'b0;
    k = 0;
    @(negedge Clk);
    while (!fb_we && k < 50) begin @(posedge Clk); k++; @(negedge Clk); end
    total++;
    if (k != 6 || {WriteX, WriteY, fb_color} !== {10'd0, 10'd0, BG}) begin
      bad++; $display("FAIL restart got=%0d:(%0d,%0d,%h) exp=6:(0,0,%h)", k, WriteX, WriteY, fb_color, BG);
    end
  endtask

`ifdef TRACE_STATS_EN
  task automatic test_stats();
    int k, done_k, p;
    logic [9:0] ex, ey;
    logic [23:0] ec;
    do_reset();
    mode = 2'd2;
    start = 1'b1; @(posedge Clk); #1 start = 1'b0;
    k = 0; done_k = -1; ex = '0; ey = '0;
    while (done_k < 0 && k < 1000) begin
      @(negedge Clk);
      if (fb_we && fb_ready) begin
        p = int'(ey) * H + int'(ex);
        ec = (p == 1 || p == 4 || p == 9) ? 24'hABCDEF : BG;
        total++;
        if (fb_color !== ec) begin bad++; $display("FAIL stats_color pix=%0d got=%h exp=%h", p, fb_color, ec); end
        if (ex == 10'(H - 1)) begin ex = '0; ey = ey + 10'd1; end else ex = ex + 10'd1;
      end
      if (frame_done) begin
        done_k = k;
        total++;
        if (hit_count !== 19'd3) begin bad++; $display("FAIL hit_count_done got=%0d exp=3", hit_count); end
      end
      @(posedge Clk); k++;
    end
    total++;
    if (done_k != FRAME) begin bad++; $display("FAIL stats_latency got=%0d exp=%0d", done_k, FRAME); end
    repeat (5) @(negedge Clk);
    total++;
    if (hit_count !== 19'd3) begin bad++; $display("FAIL hit_count_hold got=%0d exp=3", hit_count); end
    mode = 2'd0;
    start = 1'b1; @(posedge Clk); #1 start = 1'b0;
    @(negedge Clk);
    total++;
    if (hit_count !== 19'd0) begin bad++; $display("FAIL hit_count_clear got=%0d exp=0", hit_count); end
  endtask
`endif

  initial begin
    Clk = 1'b0; Reset_n = 1'b0; start = 1'b0; fb_ready = 1'b1; mode = 2'd0;
    test_reset();
    test_full_frame();
    test_nearest();
    test_backpressure();
    test_start_mid_frame();
    test_reset_mid_test();
`ifdef TRACE_STATS_EN
    test_stats();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
